// File: rtl/fpu_task_fabric_pkg.sv
// Shared types for the FPU task fabric: FSM states, unit indices and opcode decode.
package float_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fab_state_e;

  localparam int unsigned UNIT_IDX_W = 3;
  localparam int unsigned OPC_W      = 5;

  typedef logic [UNIT_IDX_W-1:0] unit_idx_t;

  localparam unit_idx_t UNIT_FFT   = 3'd0;
  localparam unit_idx_t UNIT_SPLIT = 3'd1;
  localparam unit_idx_t UNIT_FPR   = 3'd2;
  localparam unit_idx_t UNIT_FPC   = 3'd3;
  localparam unit_idx_t UNIT_FMT   = 3'd4;

  typedef struct packed {
    logic      valid;
    unit_idx_t idx;
  } unit_sel_t;

  // opcode = {op[4:2], cls[1:0]}
  function automatic unit_sel_t decode_unit(input logic [OPC_W-1:0] opcode);
    logic [2:0] op;
    logic [1:0] cls;
    unit_sel_t  sel;
    op  = opcode[4:2];
    cls = opcode[1:0];
    sel.valid = 1'b0;
    sel.idx   = UNIT_FFT;
    case (cls)
      2'b00: begin
        if (op <= 3'd1) begin
          sel.valid = 1'b1;
          sel.idx   = UNIT_FFT;
        end else if (op <= 3'd5) begin
          sel.valid = 1'b1;
          sel.idx   = UNIT_SPLIT;
        end
      end
      2'b01: begin
        sel.valid = (op <= 3'd4);
        sel.idx   = UNIT_FPR;
      end
      2'b10: begin
        sel.valid = (op <= 3'd4);
        sel.idx   = UNIT_FPC;
      end
      default: begin
        sel.valid = (op <= 3'd1);
        sel.idx   = UNIT_FMT;
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fpu_task_fabric_if.sv
// Shared memory-port bus between the task fabric (master) and the memory (slave).
interface fpu_task_fabric_if #(
  parameter int unsigned N_RD = 6,
  parameter int unsigned N_WR = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 128
);
  logic [N_RD-1:0]    m_rd_en;
  logic [N_RD*AW-1:0] m_rd_addr;
  logic [N_RD*DW-1:0] m_rd_data;
  logic [N_WR-1:0]    m_wr_en;
  logic [N_WR*AW-1:0] m_wr_addr;
  logic [N_WR*DW-1:0] m_wr_data;

  modport master (
    output m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data,
    input  m_rd_data
  );

  modport slave (
    input  m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data,
    output m_rd_data
  );
endinterface

// File: rtl/fpu_task_fabric_rd_vld_pipe.sv
// Single-port read-valid delay line of RD_LAT stages, cleared synchronously while the fabric idles.
module fab_rd_vld_pipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic vld_in,
  output logic vld_out
);

  logic [RD_LAT-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= vld_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign vld_out = sr_q[RD_LAT-1];

endmodule

// File: rtl/fpu_task_fabric.sv
// Owner-gated task dispatcher and memory-port fabric for the FPU cluster.
// Optional macro FPU_FABRIC_CONFLICT_CHECK_EN enables the sticky non-owner access flag.
module fpu_task_fabric
  import float_pkg::*;
#(
  parameter int unsigned N_UNIT = 5,
  parameter int unsigned N_RD   = 6,
  parameter int unsigned N_WR   = 4,
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 128,
  parameter int unsigned TASK_W = 11,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        task_start,
  input  logic [TASK_W-1:0]           task_word,
  output logic                        task_done,
  output logic                        task_err,
  output logic                        busy,
  output logic                        conflict_err,
  output logic [N_UNIT-1:0]           unit_start,
  output logic [TASK_W-1:0]           unit_task,
  input  logic [N_UNIT-1:0]           unit_done,
  input  logic [N_UNIT*N_RD-1:0]      u_rd_en,
  input  logic [N_UNIT*N_RD*AW-1:0]   u_rd_addr,
  output logic [N_RD*DW-1:0]          u_rd_data,
  output logic [N_UNIT*N_RD-1:0]      u_rd_vld,
  input  logic [N_UNIT*N_WR-1:0]      u_wr_en,
  input  logic [N_UNIT*N_WR*AW-1:0]   u_wr_addr,
  input  logic [N_UNIT*N_WR*DW-1:0]   u_wr_data,
  fpu_task_fabric_if.master           mem
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  fab_state_e  state_q, state_d;
  unit_idx_t   owner_q;
  logic [CNT_W-1:0] cnt_q;
  unit_sel_t   dec;
  logic        dec_ok;
  logic        accept, reject, drain_end, owner_done;
  logic [N_UNIT-1:0] start_vec;

  logic [N_RD-1:0]    rd_en_sel;
  logic [N_RD*AW-1:0] rd_addr_sel;
  logic [N_WR-1:0]    wr_en_sel;
  logic [N_WR*AW-1:0] wr_addr_sel;
  logic [N_WR*DW-1:0] wr_data_sel;
  logic [N_RD-1:0]    vld_tail;
  logic               pipe_clr;

  always_comb begin
    dec    = decode_unit(task_word[TASK_W-1 -: OPC_W]);
    dec_ok = dec.valid && (32'(dec.idx) < N_UNIT);
  end

  always_comb begin
    start_vec  = '0;
    owner_done = 1'b0;
    for (int unsigned u = 0; u < N_UNIT; u++) begin
      if (dec.idx == unit_idx_t'(u)) start_vec[u] = 1'b1;
      if (owner_q == unit_idx_t'(u)) owner_done = unit_done[u];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    drain_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (task_start) begin
          if (dec_ok) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        reject = task_start;
        if (owner_done) state_d = DRAIN;
      end
      DRAIN: begin
        reject = task_start;
        if (cnt_q == '0) begin
          drain_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= '0;
      unit_task  <= '0;
      cnt_q      <= '0;
      unit_start <= '0;
      task_err   <= 1'b0;
    end else begin
      unit_start <= '0;
      task_err   <= reject;
      if (accept) begin
        owner_q    <= dec.idx;
        unit_task  <= task_word;
        unit_start <= start_vec;
      end
      // Counter reaches 0 exactly RD_LAT cycles into DRAIN, covering the last RUN-cycle read.
      if (state_q == RUN && owner_done) begin
        cnt_q <= CNT_W'(RD_LAT);
      end else if (state_q == DRAIN && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign task_done = drain_end;
  assign busy      = (state_q != IDLE);

  always_comb begin
    rd_en_sel   = '0;
    rd_addr_sel = '0;
    wr_en_sel   = '0;
    wr_addr_sel = '0;
    wr_data_sel = '0;
    if (state_q == RUN) begin
      for (int unsigned u = 0; u < N_UNIT; u++) begin
        if (owner_q == unit_idx_t'(u)) begin
          for (int unsigned p = 0; p < N_RD; p++) begin
            rd_en_sel[p] = u_rd_en[u*N_RD+p];
            if (u_rd_en[u*N_RD+p])
              rd_addr_sel[p*AW +: AW] = u_rd_addr[(u*N_RD+p)*AW +: AW];
          end
          for (int unsigned p = 0; p < N_WR; p++) begin
            wr_en_sel[p] = u_wr_en[u*N_WR+p];
            if (u_wr_en[u*N_WR+p]) begin
              wr_addr_sel[p*AW +: AW] = u_wr_addr[(u*N_WR+p)*AW +: AW];
              wr_data_sel[p*DW +: DW] = u_wr_data[(u*N_WR+p)*DW +: DW];
            end
          end
        end
      end
    end
  end

  assign mem.m_rd_en   = rd_en_sel;
  assign mem.m_rd_addr = rd_addr_sel;
  assign mem.m_wr_en   = wr_en_sel;
  assign mem.m_wr_addr = wr_addr_sel;
  assign mem.m_wr_data = wr_data_sel;
  assign u_rd_data     = mem.m_rd_data;

  assign pipe_clr = (state_q == IDLE);

  for (genvar p = 0; p < N_RD; p++) begin : g_rd_pipe
    fab_rd_vld_pipe #(
      .RD_LAT(RD_LAT)
    ) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (pipe_clr),
      .vld_in (rd_en_sel[p]),
      .vld_out(vld_tail[p])
    );
  end

  always_comb begin
    u_rd_vld = '0;
    for (int unsigned u = 0; u < N_UNIT; u++) begin
      if (owner_q == unit_idx_t'(u)) u_rd_vld[u*N_RD +: N_RD] = vld_tail;
    end
  end

`ifdef FPU_FABRIC_CONFLICT_CHECK_EN
  logic foreign_en;

  always_comb begin
    foreign_en = 1'b0;
    if (state_q == RUN) begin
      for (int unsigned u = 0; u < N_UNIT; u++) begin
        if (owner_q != unit_idx_t'(u))
          foreign_en = foreign_en | (|u_rd_en[u*N_RD +: N_RD]) | (|u_wr_en[u*N_WR +: N_WR]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          conflict_err <= 1'b0;
    else if (accept)     conflict_err <= 1'b0;
    else if (foreign_en) conflict_err <= 1'b1;
  end
`else
  assign conflict_err = 1'b0;
`endif

endmodule

// File: doc/fpu_task_fabric.md
# fpu_task_fabric

Parametrised task dispatcher and memory-port fabric for the floating-point arithmetic cluster. Decodes each incoming task word, latches a single owner among `N_UNIT` execution units (FFT, SPLIT, FPR, FPC, FORMAT), and routes only that owner's read/write ports onto the shared memory ports. Read-valid is returned to the owner after a configurable latency, and completion is held back until in-flight reads drain. It sits between the top-level task sequencer and the per-operator units, and replaces the priority-case fabric with an owner-gated, latency-aware one.

## Interface
Parameters:
- `N_UNIT`, 5: number of execution units
- `N_RD`, 6: read ports per unit, equal to memory read ports
- `N_WR`, 4: write ports per unit, equal to memory write ports
- `AW`, 10: address width
- `DW`, 128: data width
- `TASK_W`, 11: task word width; opcode field is `[10:6]`
- `RD_LAT`, 1: memory read latency in cycles, ≥1

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `task_start`  in  1  task request pulse
- `task_word`  in  `TASK_W`  task descriptor
- `task_done`  out  1  completion pulse
- `task_err`  out  1  rejected-start pulse
- `busy`  out  1  task in progress; also drives the FPU enable
- `conflict_err`  out  1  sticky non-owner access flag
- `unit_start`  out  `N_UNIT`  one-hot start pulse
- `unit_task`  out  `TASK_W`  latched task word
- `unit_done`  in  `N_UNIT`  per-unit done
- `u_rd_en`  in  `N_UNIT*N_RD`;  `u_rd_addr`  in  `N_UNIT*N_RD*AW`
- `u_rd_data`  out  `N_RD*DW`  broadcast to all units
- `u_rd_vld`  out  `N_UNIT*N_RD`  owner-only read-data valid
- `u_wr_en`  in  `N_UNIT*N_WR`;  `u_wr_addr`  in  `N_UNIT*N_WR*AW`;  `u_wr_data`  in  `N_UNIT*N_WR*DW`
- `m_rd_en`  out  `N_RD`;  `m_rd_addr`  out  `N_RD*AW`;  `m_rd_data`  in  `N_RD*DW`
- `m_wr_en`  out  `N_WR`;  `m_wr_addr`  out  `N_WR*AW`;  `m_wr_data`  out  `N_WR*DW`

## Operation
- Opcode decode of `{op[4:2], cls[1:0]}`:
  - cls 00, op 0–1 → unit 0
  - cls 00, op 2–5 → unit 1
  - cls 01, op 0–4 → unit 2
  - cls 10, op 0–4 → unit 3
  - cls 11, op 0–1 → unit 4
  - anything else is invalid.
- FSM states IDLE, RUN, DRAIN:
  - IDLE + `task_start` + valid opcode: latch `owner` and `unit_task`, then go to RUN.
  - IDLE + `task_start` + invalid opcode: pulse `task_err`, stay in IDLE.
  - RUN + `unit_done[owner]`: load the drain counter with `RD_LAT`, go to DRAIN.
  - DRAIN: decrement the counter; at 0, pulse `task_done` and go to IDLE.
- Routing:
  - In RUN, `m_*` carries the owner's ports only.
  - In IDLE and DRAIN, all `m_*_en` are 0.
  - When an enable is 0, its addr/data outputs are 0 (never X).
- Read return:
  - Each read port has an `RD_LAT`-deep valid shift register fed by `m_rd_en`.
  - `u_rd_vld[owner*N_RD+p]` is the tail of port p's shift register; all non-owner bits are 0.
- Ignored inputs:
  - `unit_done` from a non-owner has no effect.
  - `task_start` outside IDLE is ignored and pulses `task_err`.
- Reset values: all outputs are 0, `owner` is 0, the FSM is in IDLE, and the shift registers are cleared. Reset mid-task aborts without `task_done`.

## Timing
- `task_start` at cycle 0 → `unit_start[owner]` is a one-cycle pulse at cycle 1; `busy` is high from cycle 1.
- Memory read at cycle t → `u_rd_vld` at cycle t+`RD_LAT`.
- `unit_done[owner]` sampled at cycle t → `task_done` at t+`RD_LAT`+1; `busy` falls at t+`RD_LAT`+2.
- The earliest accepted back-to-back `task_start` is in the cycle after `task_done`.

## Configuration
- Macro: `FPU_FABRIC_CONFLICT_CHECK_EN`.
- Defined:
  - In RUN, any non-owner `u_rd_en`/`u_wr_en` sets `conflict_err`.
  - `conflict_err` is sticky and clears on the next accepted `task_start`.
  - Routing is unchanged.
- Undefined: `conflict_err` is tied to 0, and non-owner enables are silently dropped.

## Structure
- Package `float_pkg` holds:
  - the state enum `fab_state_e`
  - the unit index constants `UNIT_FFT`..`UNIT_FMT`
  - the function `decode_unit(opcode)`, returning `{valid, idx}`
- One sub-module, `fab_rd_vld_pipe`: a per-port `RD_LAT` valid shift register with synchronous clear on IDLE.

## Test plan
- Task word opcode 5'b010_01 (unit 2), with unit 2 reading port 0 at addr 0x3A → `m_rd_addr[0]=0x3A`, `u_rd_vld[2*N_RD+0]` high `RD_LAT` cycles later, and all other vld bits 0.
- Opcode 5'b110_00 → `task_err` pulses for one cycle, no `unit_start`, `busy` stays 0.
- `RD_LAT`=3, `unit_done[2]` at cycle 10 → `task_done` exactly at cycle 14, with no `m_*_en` during DRAIN.
- Owner unit 0 and non-owner unit 3 both write to port 1 → only unit 0's data reaches `m_wr_data[1]`; `conflict_err`=1 with the macro, 0 without.
- `task_start` during RUN → ignored, `task_err` pulses, owner unchanged.
- `rst_n` low mid-RUN → all outputs 0 immediately; no `task_done` after release.
